// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback path.
package wb_pkg;

  localparam int unsigned REG_SIZE  = 16;
  localparam int unsigned VEC_SIZE  = 4;
  localparam int unsigned SEL_BITS  = 3;
  localparam int unsigned REG_TOTAL = 2 ** SEL_BITS;
  localparam int unsigned DATA_W    = REG_SIZE * VEC_SIZE;

  typedef struct packed {
    logic [SEL_BITS-1:0] dest;
    logic [DATA_W-1:0]   data;
  } wb_entry_t;

  // The second-highest selector bit splits the register space into scalar and vector halves.
  function automatic logic is_scalar(input logic [SEL_BITS-1:0] dest);
    return dest[SEL_BITS-2];
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding load results until the writeback arbiter drains them.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  wb_entry_t         mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW + 1)'(Depth));
  assign do_pop  = pop && !empty;
  // A pop frees the head slot, so a full FIFO can still take a push in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and load results into one register-file write stream and tracks pending writes.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  input  logic [SEL_BITS-1:0] alu_dest,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_stall,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [SEL_BITS-1:0] mem_dest,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                issue_valid,
  input  logic [SEL_BITS-1:0] issue_dest,
  input  logic [SEL_BITS-1:0] query_sel1,
  input  logic [SEL_BITS-1:0] query_sel2,
  output logic                busy1,
  output logic                busy2,
  output logic                regWrEnScalar,
  output logic                regWrEnVector,
  output logic [SEL_BITS-1:0] regToWrite,
  output logic [DATA_W-1:0]   dataIn,
  output logic                proto_err
);

  localparam int unsigned       CntW   = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CntW-1:0]   CntMax = CntW'(STARVE_LIMIT - 1);

  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_entry_t            fifo_head, mem_entry, sel;
  logic                 sel_valid;
  logic [CntW-1:0]      starve_q, starve_d;
  logic                 stall_q, stall_d;
  logic                 proto_q, proto_d;
  logic [REG_TOTAL-1:0] busy_q, busy_d;
  logic                 we_s_q, we_s_d, we_v_q, we_v_d;
  logic [SEL_BITS-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;

  assign mem_entry = '{dest: mem_dest, data: mem_data};
  assign fifo_push = mem_valid && !fifo_full;
  assign fifo_pop  = !alu_valid && !fifo_empty;

  wb_fifo #(
    .Depth(MEM_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (mem_entry),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (fifo_head)
  );

  // ALU always wins, even during a stall, so a protocol violation never drops a result.
  assign sel_valid = alu_valid || !fifo_empty;
  assign sel       = alu_valid ? '{dest: alu_dest, data: alu_data} : fifo_head;

  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    proto_d  = proto_q | (alu_valid & stall_q);
    if (!alu_valid || fifo_empty) begin
      starve_d = '0;
    end else begin
      // Saturates at the limit; one more starving win raises the stall.
      stall_d = (starve_q == CntMax);
      if (starve_q != CntMax) starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (we_s_q || we_v_q) busy_d[addr_q] = 1'b0;
    if (issue_valid)      busy_d[issue_dest] = 1'b1;
  end

  always_comb begin
    we_s_d = sel_valid && is_scalar(sel.dest);
    we_v_d = sel_valid && !is_scalar(sel.dest);
    addr_d = sel_valid ? sel.dest : '0;
    data_d = sel_valid ? sel.data : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
      proto_q  <= 1'b0;
      busy_q   <= '0;
      we_s_q   <= 1'b0;
      we_v_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
      proto_q  <= proto_d;
      busy_q   <= busy_d;
      we_s_q   <= we_s_d;
      we_v_q   <= we_v_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign alu_stall     = stall_q;
  assign mem_ready     = !fifo_full;
  assign busy1         = busy_q[query_sel1];
  assign busy2         = busy_q[query_sel2];
  assign regWrEnScalar = we_s_q;
  assign regWrEnVector = we_v_q;
  assign regToWrite    = addr_q;
  assign dataIn        = data_q;
  assign proto_err     = proto_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Randomised bench for writeback_unit: queue-based reference model feeding a commit scoreboard.
module tb_writeback_unit;

  localparam int Depth = 2;
  localparam int Limit = 4;

  typedef struct packed {
    logic [2:0]  dest;
    logic [63:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0;
  logic [2:0]  alu_dest = '0, mem_dest = '0, issue_dest = '0, query_sel1 = '0, query_sel2 = '0;
  logic [63:0] alu_data = '0, mem_data = '0;
  logic        alu_stall, mem_ready, busy1, busy2, regWrEnScalar, regWrEnVector, proto_err;
  logic [2:0]  regToWrite;
  logic [63:0] dataIn;

  logic              f_push = 1'b0, f_pop = 1'b0, f_full, f_empty;
  wb_pkg::wb_entry_t f_din, f_head;

  int errors = 0;
  int checks = 0;

  // Reference model state
  ent_t       mq[$];
  ent_t       exp_q[$];
  logic [7:0] m_busy;
  int         wins;
  logic       m_stall, m_proto, pv;
  logic [2:0] pdest;

  always #5 clk = ~clk;

  writeback_unit #(
    .MEM_DEPTH   (Depth),
    .STARVE_LIMIT(Limit)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_dest     (alu_dest),
    .alu_data     (alu_data),
    .alu_stall    (alu_stall),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_dest     (mem_dest),
    .mem_data     (mem_data),
    .issue_valid  (issue_valid),
    .issue_dest   (issue_dest),
    .query_sel1   (query_sel1),
    .query_sel2   (query_sel2),
    .busy1        (busy1),
    .busy2        (busy2),
    .regWrEnScalar(regWrEnScalar),
    .regWrEnVector(regWrEnVector),
    .regToWrite   (regToWrite),
    .dataIn       (dataIn),
    .proto_err    (proto_err)
  );

  wb_fifo #(
    .Depth(2)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (f_push),
    .pop  (f_pop),
    .din  (f_din),
    .full (f_full),
    .empty(f_empty),
    .head (f_head)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_busy  = '0;
    wins    = 0;
    m_stall = 1'b0;
    m_proto = 1'b0;
    pv      = 1'b0;
    pdest   = '0;
  endtask

  // One cycle of the spec's rules, applied to the inputs just sampled by the DUT.
  task automatic model_update();
    ent_t e;
    int   pre_size;
    logic cv, nstall;
    logic [2:0] cdest;
    pre_size = mq.size();
    cv = 1'b0; nstall = 1'b0; cdest = '0;
    if (alu_valid) begin
      exp_q.push_back('{dest: alu_dest, data: alu_data});
      if (m_stall) m_proto = 1'b1;
      wins   = (pre_size != 0) ? wins + 1 : 0;
      nstall = (pre_size != 0) && (wins >= Limit);
      cv = 1'b1; cdest = alu_dest;
    end else if (pre_size != 0) begin
      e = mq.pop_front();
      exp_q.push_back(e);
      wins = 0;
      cv = 1'b1; cdest = e.dest;
    end else begin
      wins = 0;
    end
    if (mem_valid && pre_size < Depth) mq.push_back('{dest: mem_dest, data: mem_data});
    if (pv) m_busy[pdest] = 1'b0;
    if (issue_valid) m_busy[issue_dest] = 1'b1;
    pv = cv; pdest = cdest; m_stall = nstall;
  endtask

  task automatic check_outputs();
    chk("mem_ready", mem_ready, (mq.size() < Depth));
    chk("alu_stall", alu_stall, m_stall);
    chk("proto_err", proto_err, m_proto);
    chk("busy1", busy1, m_busy[query_sel1]);
    chk("busy2", busy2, m_busy[query_sel2]);
    chk("commit_present", regWrEnScalar | regWrEnVector, pv);
  endtask

  task automatic step(input logic a_v, input logic [2:0] a_d, input logic [63:0] a_dat,
                      input logic m_v, input logic [2:0] m_d, input logic [63:0] m_dat,
                      input logic i_v, input logic [2:0] i_d,
                      input logic [2:0] s1, input logic [2:0] s2);
    alu_valid = a_v; alu_dest = a_d; alu_data = a_dat;
    mem_valid = m_v; mem_dest = m_d; mem_data = m_dat;
    issue_valid = i_v; issue_dest = i_d;
    query_sel1 = s1; query_sel2 = s2;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic [2:0] s1);
    step(1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 64'd0, 1'b0, 3'd0, s1, 3'd0);
  endtask

  task automatic alu(input logic [2:0] d, input logic m_v);
    step(1'b1, d, {$urandom, $urandom}, m_v, 3'($urandom), {$urandom, $urandom},
         1'b0, 3'd0, 3'd0, 3'd0);
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic fcycle(input logic p, input logic q, input logic [2:0] d, input logic [63:0] v);
    f_push = p; f_pop = q; f_din.dest = d; f_din.data = v;
    @(posedge clk);
    @(negedge clk);
    f_push = 1'b0; f_pop = 1'b0;
  endtask

  // Commit scoreboard: every write the DUT presents must match the next expected commit.
  always @(negedge clk) begin
    ent_t e;
    if (regWrEnScalar || regWrEnVector) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got dest %0d data %0h expected none", regToWrite, dataIn);
      end else begin
        e = exp_q.pop_front();
        chk("commit_dest", regToWrite, e.dest);
        chk("commit_data", dataIn, e.data);
        chk("commit_scalar", regWrEnScalar, e.dest[1]);
        chk("commit_vector", regWrEnVector, !e.dest[1]);
      end
    end
  end

  initial begin
    int n;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_mem_ready", mem_ready, 1'b1);
    chk("rst_enables", {regWrEnScalar, regWrEnVector}, 2'b00);
    chk("rst_data", dataIn, 64'd0);
    #1 reset = 1'b1;

    // Scalar ALU write
    step(1'b1, 3'b010, 64'h0004_0003_0002_0001, 1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 3'd0, 3'd0);
    chk("alu_scalar_en", regWrEnScalar, 1'b1);
    chk("alu_vector_en", regWrEnVector, 1'b0);
    chk("alu_addr", regToWrite, 3'd2);
    chk("alu_data", dataIn, 64'h0004_0003_0002_0001);

    // Load into idle unit: no enable after one cycle, vector enable after two
    step(1'b0, 3'd0, 64'd0, 1'b1, 3'b001, 64'hdead_beef_0bad_f00d, 1'b0, 3'd0, 3'd0, 3'd0);
    chk("load_gap", {regWrEnScalar, regWrEnVector}, 2'b00);
    idle(3'd0);
    chk("load_vector_en", regWrEnVector, 1'b1);
    chk("load_addr", regToWrite, 3'd1);

    // Scoreboard set/clear and set-wins-over-clear
    step(1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 64'd0, 1'b1, 3'd5, 3'd5, 3'd0);
    chk("busy_set", busy1, 1'b1);
    step(1'b1, 3'd5, 64'h55, 1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 3'd5, 3'd0);
    chk("busy_before_capture", busy1, 1'b1);
    idle(3'd5);
    chk("busy_cleared", busy1, 1'b0);
    step(1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 64'd0, 1'b1, 3'd5, 3'd5, 3'd0);
    step(1'b1, 3'd5, 64'h66, 1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 3'd5, 3'd0);
    step(1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 64'd0, 1'b1, 3'd5, 3'd5, 3'd0);
    chk("busy_set_wins", busy1, 1'b1);
    idle(3'd5);
    chk("busy_still_set", busy1, 1'b1);

    // Starvation: fill buffer under ALU traffic until stall
    alu(3'd2, 1'b1);
    alu(3'd1, 1'b1);
    chk("full_not_ready", mem_ready, 1'b0);
    n = 0;
    while (!m_stall && n < 10) begin
      alu(3'($urandom), 1'b0);
      n++;
    end
    chk("stall_after_wins", alu_stall, 1'b1);
    // Honoured stall: head commits, mem offer refused while full
    step(1'b0, 3'd0, 64'd0, 1'b1, 3'd3, 64'h77, 1'b0, 3'd0, 3'd0, 3'd0);
    chk("stall_released", alu_stall, 1'b0);
    n = 0;
    while (!m_stall && n < 10) begin
      alu(3'($urandom), 1'b0);
      n++;
    end
    chk("stall_again", alu_stall, 1'b1);
    alu(3'd6, 1'b0);
    chk("proto_err_set", proto_err, 1'b1);
    repeat (4) idle(3'd0);
    chk("proto_err_sticky", proto_err, 1'b1);

    // Reset mid-stream with buffer full and pending bits
    step(1'b1, 3'd0, 64'h1, 1'b1, 3'd4, 64'h2, 1'b1, 3'd4, 3'd0, 3'd0);
    step(1'b1, 3'd3, 64'h3, 1'b1, 3'd7, 64'h4, 1'b1, 3'd7, 3'd4, 3'd7);
    do_reset();
    @(negedge clk);
    chk("post_rst_ready", mem_ready, 1'b1);
    chk("post_rst_busy", {busy1, busy2}, 2'b00);
    chk("post_rst_enables", {regWrEnScalar, regWrEnVector}, 2'b00);
    chk("post_rst_proto", proto_err, 1'b0);
    idle(3'd4);

    // Direct FIFO: push+pop while full keeps it full and order holds across wrap
    fcycle(1'b1, 1'b0, 3'd1, 64'hA);
    fcycle(1'b1, 1'b0, 3'd2, 64'hB);
    chk("fifo_full", f_full, 1'b1);
    chk("fifo_head_a", f_head.data, 64'hA);
    fcycle(1'b1, 1'b1, 3'd3, 64'hC);
    chk("fifo_full_pp1", f_full, 1'b1);
    chk("fifo_head_b", f_head.data, 64'hB);
    fcycle(1'b1, 1'b1, 3'd4, 64'hD);
    chk("fifo_full_pp2", f_full, 1'b1);
    chk("fifo_head_c", f_head.data, 64'hC);
    fcycle(1'b0, 1'b1, 3'd0, 64'h0);
    chk("fifo_head_d", f_head.data, 64'hD);
    chk("fifo_not_full", f_full, 1'b0);
    fcycle(1'b0, 1'b1, 3'd0, 64'h0);
    chk("fifo_empty", f_empty, 1'b1);

    // Random traffic; ALU honours the model's stall
    for (int i = 0; i < 400; i++) begin
      step(!m_stall && ($urandom_range(0, 3) != 0), 3'($urandom), {$urandom, $urandom},
           $urandom_range(0, 1) == 1, 3'($urandom), {$urandom, $urandom},
           $urandom_range(0, 2) == 0, 3'($urandom), 3'($urandom), 3'($urandom));
    end
    repeat (6) idle(3'($urandom));
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
